accum_sweep_ctrl: RTL and testbench

- Sequencer for the shift-accumulate pixel RAM: one bit plane per camera frame shifted into per-pixel code words.
- Accepts one command at a time: accumulate sweep, readout sweep, or single-address disable.
- Walks all DEPTH addresses and drives the RAM request port; tracks bit planes accumulated.
- Streams decoded codes out with valid/ready backpressure to downstream LED-ID logic.

---
 rtl/accum_ctrl_pkg.sv | 5 +
 rtl/accum_readout_fifo.sv | 40 ++++
 rtl/accum_sweep_ctrl.sv | 117 +++++++++++
 tb/tb_accum_sweep_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/accum_ctrl_pkg.sv
// accum_ctrl_pkg: request and command encodings shared by the sweep controller and the pixel RAM
package accum_ctrl_pkg;
  typedef enum logic [1:0] {REQ_READ, REQ_WRITE, REQ_WRITE_OVER, REQ_DISABLE} accum_request_t;
  typedef enum logic [1:0] {CMD_ACCUM, CMD_READOUT, CMD_DISABLE, CMD_RESTART} sweep_cmd_t;
endpackage

// File: rtl/accum_readout_fifo.sv
// accum_readout_fifo: skid buffer of {code, pixel address} between RAM read returns and downstream
module accum_readout_fifo #(
  parameter int WIDTH = 16,
  parameter int AW = 12,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             push_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    addr_in,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [WIDTH-1:0] data_out,
  output logic [AW-1:0]    addr_out,
  output logic [CW-1:0]    count_out
);
  logic [WIDTH+AW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic pop;
  assign valid_out = count_q != '0;
  assign pop = valid_out && ready_in;
  assign {data_out, addr_out} = valid_out ? mem[rd_q] : '0;
  assign count_out = count_q;
  always_ff @(posedge clk_in) if (push_in) mem[wr_q] <= {data_in, addr_in};
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_q + PW'(push_in);
      rd_q <= rd_q + PW'(pop);
      count_q <= count_q + CW'(push_in) - CW'(pop);
    end
  assert property (@(posedge clk_in) disable iff (!rst_n_in) !(push_in && count_q == CW'(DEPTH)));
endmodule

// File: rtl/accum_sweep_ctrl.sv
// accum_sweep_ctrl: sequences accumulate, readout and disable sweeps over the shift-accumulate pixel RAM
module accum_sweep_ctrl
  import accum_ctrl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4096,
  parameter int CODE_BITS = 12,
  parameter int FIFO_DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int BW = $clog2(CODE_BITS + 1),
  localparam int FW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic           clk_in,
  input  logic           rst_n_in,
  input  logic           cmd_valid_in,
  output logic           cmd_ready_out,
  input  sweep_cmd_t     cmd_in,
  input  logic [AW-1:0]  cmd_addr_in,
  input  logic           bit_valid_in,
  input  logic           bit_in,
  output logic           bit_ready_out,
  output logic [AW-1:0]  ram_addr_out,
  output logic           ram_summand_out,
  output accum_request_t ram_request_type_out,
  output logic           ram_request_valid_out,
  input  logic [WIDTH-1:0] ram_read_in,
  input  accum_request_t ram_request_type_in,
  input  logic           ram_result_valid_in,
  output logic           code_valid_out,
  input  logic           code_ready_in,
  output logic [WIDTH-1:0] code_out,
  output logic [AW-1:0]  code_addr_out,
  output logic           code_disabled_out,
  output logic [BW-1:0]  bit_index_out,
  output logic           busy_out,
  output logic           sweep_done_out
);
  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_READ, S_DIS, S_DRAIN} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] addr_q, dis_addr_q, ret_a1_q, ret_a2_q;
  logic [BW-1:0] bit_idx_q;
  logic [FW-1:0] inflight_q, fifo_count;
  logic rd_done_q, drain_q, done_q;
  logic cmd_fire, acc_fire, rd_issue, rd_exit, push, dec, last, over;
  assign cmd_fire = cmd_valid_in && state_q == S_IDLE;
  assign acc_fire = state_q == S_ACCUM && bit_valid_in;
  assign last = addr_q == AW'(DEPTH - 1);
  assign over = bit_idx_q == '0 || bit_idx_q == BW'(CODE_BITS);
  // fifo entries plus reads in flight never exceed the buffer, so returns always have room
  assign rd_issue = state_q == S_READ && !rd_done_q && (int'(fifo_count) + int'(inflight_q) < FIFO_DEPTH);
  assign push = ram_result_valid_in && ram_request_type_in == REQ_READ && (state_q == S_READ || state_q == S_DRAIN);
  assign dec = push && inflight_q != '0;
  assign rd_exit = state_q == S_READ && rd_done_q && inflight_q == '0 && fifo_count == '0;
  assign cmd_ready_out = state_q == S_IDLE;
  assign bit_ready_out = state_q == S_ACCUM;
  assign busy_out = state_q != S_IDLE;
  assign sweep_done_out = done_q;
  assign bit_index_out = bit_idx_q;
  assign code_disabled_out = &code_out;
  always_comb begin
    state_d = state_q;
    ram_request_valid_out = acc_fire || rd_issue || state_q == S_DIS;
    ram_addr_out = state_q == S_DIS ? dis_addr_q : addr_q;
    ram_summand_out = acc_fire && bit_in;
    ram_request_type_out = !ram_request_valid_out ? REQ_READ : state_q == S_DIS ? REQ_DISABLE :
                           state_q == S_READ ? REQ_READ : over ? REQ_WRITE_OVER : REQ_WRITE;
    case (state_q)
      S_IDLE:  if (cmd_fire) state_d = cmd_in == CMD_ACCUM ? S_ACCUM : cmd_in == CMD_READOUT ? S_READ :
                                       cmd_in == CMD_DISABLE ? S_DIS : S_IDLE;
      S_ACCUM: if (acc_fire && last) state_d = S_DRAIN;
      S_READ:  if (rd_exit) state_d = S_IDLE;
      S_DIS:   state_d = S_DRAIN;
      S_DRAIN: if (drain_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      dis_addr_q <= '0;
      ret_a1_q <= '0;
      ret_a2_q <= '0;
      bit_idx_q <= '0;
      inflight_q <= '0;
      rd_done_q <= 1'b0;
      drain_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_a1_q <= addr_q;
      ret_a2_q <= ret_a1_q;
      drain_q <= state_q == S_DRAIN && !drain_q;
      done_q <= (state_q == S_DRAIN && drain_q) || rd_exit || (cmd_fire && cmd_in == CMD_RESTART);
      inflight_q <= inflight_q + FW'(rd_issue) - FW'(dec);
      if (cmd_fire) begin
        addr_q <= '0;
        rd_done_q <= 1'b0;
        dis_addr_q <= cmd_addr_in;
      end else if ((acc_fire || rd_issue) && !last) addr_q <= addr_q + AW'(1);
      if (rd_issue && last) rd_done_q <= 1'b1;
      if (cmd_fire && cmd_in == CMD_RESTART) bit_idx_q <= '0;
      else if (acc_fire && last) bit_idx_q <= over ? BW'(1) : bit_idx_q + BW'(1);
    end
  accum_readout_fifo #(.WIDTH(WIDTH), .AW(AW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .push_in(push),
    .data_in(ram_read_in),
    .addr_in(ret_a2_q),
    .valid_out(code_valid_out),
    .ready_in(code_ready_in),
    .data_out(code_out),
    .addr_out(code_addr_out),
    .count_out(fifo_count)
  );
endmodule

// File: tb/tb_accum_sweep_ctrl.sv
// tb_accum_sweep_ctrl: directed checks of the sweep controller against a small shift-accumulate RAM model
module tb_accum_sweep_ctrl;
  import accum_ctrl_pkg::*;
  localparam int WIDTH = 16, DEPTH = 8, CODE_BITS = 3, FIFO_DEPTH = 4, AW = 3, BW = 2;
  logic clk_in = 1'b0, rst_n_in = 1'b0;
  logic cmd_valid_in = 1'b0;
  sweep_cmd_t cmd_in = CMD_ACCUM;
  logic [AW-1:0] cmd_addr_in = '0;
  logic bit_valid_in = 1'b0, bit_in = 1'b0, code_ready_in = 1'b0;
  logic [WIDTH-1:0] ram_read_in = '0;
  accum_request_t ram_request_type_in = REQ_READ;
  logic ram_result_valid_in = 1'b0;
  logic cmd_ready_out, bit_ready_out, ram_summand_out, ram_request_valid_out;
  logic code_valid_out, code_disabled_out, busy_out, sweep_done_out;
  logic [AW-1:0] ram_addr_out, code_addr_out;
  accum_request_t ram_request_type_out;
  logic [WIDTH-1:0] code_out;
  logic [BW-1:0] bit_index_out;
  always #5 clk_in = ~clk_in;
  accum_sweep_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CODE_BITS(CODE_BITS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out), .cmd_in(cmd_in), .cmd_addr_in(cmd_addr_in),
    .bit_valid_in(bit_valid_in), .bit_in(bit_in), .bit_ready_out(bit_ready_out),
    .ram_addr_out(ram_addr_out), .ram_summand_out(ram_summand_out),
    .ram_request_type_out(ram_request_type_out), .ram_request_valid_out(ram_request_valid_out),
    .ram_read_in(ram_read_in), .ram_request_type_in(ram_request_type_in), .ram_result_valid_in(ram_result_valid_in),
    .code_valid_out(code_valid_out), .code_ready_in(code_ready_in), .code_out(code_out),
    .code_addr_out(code_addr_out), .code_disabled_out(code_disabled_out),
    .bit_index_out(bit_index_out), .busy_out(busy_out), .sweep_done_out(sweep_done_out)
  );
  typedef struct packed {accum_request_t t; logic [AW-1:0] a; logic s;} req_t;
  typedef struct packed {logic [WIDTH-1:0] d; logic [AW-1:0] a; logic dis;} code_t;
  req_t req_q[$];
  code_t code_q[$];
  logic [WIDTH-1:0] mem [DEPTH];
  logic dis_m [DEPTH];
  logic [WIDTH-1:0] exp_code [DEPTH];
  logic [AW-1:0] ra;
  logic s1v = 1'b0, s2v = 1'b0;
  logic [WIDTH-1:0] s1d = '0, s2d = '0;
  int cyc = 0, last_req_cyc = 0, done_cyc = 0, first_code_cyc = -1, last_code_cyc = 0;
  int reads = 0, pops = 0, max_out = 0, total = 0, bad = 0;
  // RAM model: writes land at the request, reads return on the third falling edge (DUT sees them 2 cycles later)
  always @(negedge clk_in) begin
    cyc++;
    if (sweep_done_out) done_cyc = cyc;
    if (code_valid_out && code_ready_in) begin
      code_q.push_back('{code_out, code_addr_out, code_disabled_out});
      if (first_code_cyc < 0) first_code_cyc = cyc;
      last_code_cyc = cyc;
      pops++;
    end
    ram_result_valid_in = s2v;
    ram_request_type_in = REQ_READ;
    ram_read_in = s2d;
    s2v = s1v;
    s2d = s1d;
    s1v = 1'b0;
    if (ram_request_valid_out) begin
      req_q.push_back('{ram_request_type_out, ram_addr_out, ram_summand_out});
      last_req_cyc = cyc;
      ra = ram_addr_out;
      case (ram_request_type_out)
        REQ_READ: begin
          s1v = 1'b1;
          s1d = mem[ra];
          reads++;
        end
        REQ_WRITE: if (!dis_m[ra]) mem[ra] = {mem[ra][WIDTH-2:0], ram_summand_out};
        REQ_WRITE_OVER: if (!dis_m[ra]) mem[ra] = {{(WIDTH-1){1'b0}}, ram_summand_out};
        default: begin
          dis_m[ra] = 1'b1;
          mem[ra] = '1;
        end
      endcase
    end
    if (reads - pops > max_out) max_out = reads - pops;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask
  task automatic send_cmd(input sweep_cmd_t c, input logic [AW-1:0] a);
    cmd_valid_in = 1'b1;
    cmd_in = c;
    cmd_addr_in = a;
    tick();
    cmd_valid_in = 1'b0;
  endtask
  task automatic wait_done(input string tag);
    int n = 0;
    while (!sweep_done_out && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 32'(sweep_done_out), 1);
    tick();
  endtask
  task automatic accum(input logic [7:0] bits, input bit tog, input accum_request_t et,
                       input logic [BW-1:0] eidx, input string tag);
    int k = 0;
    req_q.delete();
    send_cmd(CMD_ACCUM, '0);
    for (int c = 0; c < 100 && k < DEPTH; c++) begin
      bit_valid_in = tog ? c[0] : 1'b1;
      bit_in = bits[k];
      @(negedge clk_in);
      if (bit_valid_in && bit_ready_out) k++;
      tick();
    end
    bit_valid_in = 1'b0;
    wait_done({tag, "_done"});
    chk({tag, "_nreq"}, req_q.size(), DEPTH);
    foreach (req_q[i]) begin
      chk({tag, "_addr"}, 32'(req_q[i].a), i);
      chk({tag, "_type"}, 32'(req_q[i].t), 32'(et));
      chk({tag, "_summand"}, 32'(req_q[i].s), 32'(bits[i]));
    end
    chk({tag, "_drain_lat"}, done_cyc - last_req_cyc, 3);
    chk({tag, "_idx"}, 32'(bit_index_out), 32'(eidx));
  endtask
  task automatic readout(input int stall, input string tag);
    code_q.delete();
    reads = 0;
    pops = 0;
    max_out = 0;
    first_code_cyc = -1;
    code_ready_in = stall == 0;
    send_cmd(CMD_READOUT, '0);
    if (stall > 0) begin
      repeat (stall) tick();
      chk({tag, "_stall_reads"}, reads, FIFO_DEPTH);
      code_ready_in = 1'b1;
    end
    wait_done({tag, "_done"});
    code_ready_in = 1'b0;
    chk({tag, "_ncode"}, code_q.size(), DEPTH);
    foreach (code_q[i]) begin
      chk({tag, "_addr"}, 32'(code_q[i].a), i);
      chk({tag, "_code"}, 32'(code_q[i].d), 32'(exp_code[i]));
      chk({tag, "_disabled"}, 32'(code_q[i].dis), 32'(exp_code[i] == '1));
    end
    if (stall > 0) chk({tag, "_max_outstanding"}, max_out, FIFO_DEPTH);
    else chk({tag, "_throughput"}, last_code_cyc - first_code_cyc, DEPTH - 1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = '0;
      dis_m[i] = 1'b0;
    end
    repeat (2) tick();
    chk("rst_cmd_ready", 32'(cmd_ready_out), 1);
    chk("rst_busy", 32'(busy_out), 0);
    chk("rst_bit_ready", 32'(bit_ready_out), 0);
    chk("rst_req_valid", 32'(ram_request_valid_out), 0);
    chk("rst_req_type", 32'(ram_request_type_out), 0);
    chk("rst_code_valid", 32'(code_valid_out), 0);
    chk("rst_code", 32'(code_out), 0);
    chk("rst_bit_index", 32'(bit_index_out), 0);
    chk("rst_done", 32'(sweep_done_out), 0);
    rst_n_in = 1'b1;
    tick();
    accum(8'hA5, 1'b1, REQ_WRITE_OVER, 2'd1, "acc1");
    accum(8'h0F, 1'b0, REQ_WRITE, 2'd2, "acc2");
    accum(8'h3C, 1'b0, REQ_WRITE, 2'd3, "acc3");
    exp_code = '{16'd6, 16'd2, 16'd7, 16'd3, 16'd1, 16'd5, 16'd0, 16'd4};
    readout(0, "rd1");
    chk("rd1_idx", 32'(bit_index_out), 3);
    accum(8'h20, 1'b0, REQ_WRITE_OVER, 2'd1, "acc4");
    req_q.delete();
    send_cmd(CMD_DISABLE, 3'd2);
    wait_done("dis_done");
    chk("dis_nreq", req_q.size(), 1);
    chk("dis_type", 32'(req_q[0].t), 32'(REQ_DISABLE));
    chk("dis_addr", 32'(req_q[0].a), 2);
    accum(8'h00, 1'b0, REQ_WRITE, 2'd2, "acc5");
    exp_code = '{16'd0, 16'd0, 16'hFFFF, 16'd0, 16'd0, 16'd2, 16'd0, 16'd0};
    readout(10, "rd2");
    send_cmd(CMD_RESTART, '0);
    chk("restart_done", 32'(sweep_done_out), 1);
    chk("restart_idx", 32'(bit_index_out), 0);
    tick();
    chk("restart_pulse_end", 32'(sweep_done_out), 0);
    accum(8'h00, 1'b0, REQ_WRITE_OVER, 2'd1, "acc6");
    send_cmd(CMD_ACCUM, '0);
    bit_valid_in = 1'b1;
    bit_in = 1'b1;
    repeat (4) tick();
    chk("mid_addr", 32'(ram_addr_out), 4);
    chk("mid_type", 32'(ram_request_type_out), 32'(REQ_WRITE));
    chk("mid_req_valid", 32'(ram_request_valid_out), 1);
    #2 rst_n_in = 1'b0;
    #1;
    chk("arst_req_valid", 32'(ram_request_valid_out), 0);
    chk("arst_busy", 32'(busy_out), 0);
    chk("arst_bit_ready", 32'(bit_ready_out), 0);
    chk("arst_addr", 32'(ram_addr_out), 0);
    chk("arst_idx", 32'(bit_index_out), 0);
    chk("arst_cmd_ready", 32'(cmd_ready_out), 1);
    bit_valid_in = 1'b0;
    tick();
    rst_n_in = 1'b1;
    tick();
    req_q.delete();
    bit_valid_in = 1'b1;
    repeat (3) tick();
    bit_valid_in = 1'b0;
    chk("idle_bits_ignored", req_q.size(), 0);
    accum(8'h5A, 1'b0, REQ_WRITE_OVER, 2'd1, "acc7");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
